// File: rtl/parity_check_pkg.sv
// rtl/parity_check_pkg.sv - shared encodings and parity helper for parity_check_seq
package parity_check_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam int MIN_DATA_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // acc is the XOR of all data bits received so far
    function automatic logic expected_parity(input logic [1:0] mode, input logic acc);
        logic exp_bit;
        case (mode)
            PAR_EVEN:  exp_bit = acc;
            PAR_ODD:   exp_bit = ~acc;
            PAR_MARK:  exp_bit = 1'b1;
            default:   exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/parity_check_seq_if.sv
// rtl/parity_check_seq_if.sv - serial bit stream from the Rx sampler into the parity checker
interface parity_check_seq_if;
    logic frame_start;
    logic bit_valid;
    logic sampled_bit;

    modport master (output frame_start, output bit_valid, output sampled_bit);
    modport slave  (input  frame_start, input  bit_valid, input  sampled_bit);
endinterface

// File: rtl/parity_err_counter.sv
// rtl/parity_err_counter.sv - saturating parity error counter with clear
module parity_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_check_seq.sv
// rtl/parity_check_seq.sv - bit-serial UART Rx data assembler and parity checker
// Optional error counter enabled by macro PARITY_ERR_CNT_EN.
module parity_check_seq
    import parity_check_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    parity_check_seq_if.slave     rx,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  par_chk_en,
    input  logic [1:0]            par_mode,
    input  logic                  err_cnt_clr,
    output logic [DATA_WIDTH-1:0] data_bits,
    output logic                  parity_done,
    output logic                  parity_error,
    output logic                  busy,
    output logic [CNT_W-1:0]      err_count
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_clamped;
    logic             chk_q;
    logic [1:0]       mode_q;
    logic             acc;
    logic             start;
    logic             last_bit;
    logic             par_bad;
    logic             err_inc;

    always_comb begin
        len_clamped = data_len;
        if (data_len < LEN_W'(MIN_DATA_LEN)) begin
            len_clamped = LEN_W'(MIN_DATA_LEN);
        end else if (data_len > LEN_W'(DATA_WIDTH)) begin
            len_clamped = LEN_W'(DATA_WIDTH);
        end
    end

    // a frame_start seen in DONE is dropped; elsewhere it (re)starts a frame
    assign start    = rx.frame_start && (state != ST_DONE);
    assign last_bit = (cnt == len_q - LEN_W'(1));
    assign par_bad  = (rx.sampled_bit != expected_parity(mode_q, acc));
    assign err_inc  = (state == ST_PARITY) && rx.bit_valid && !rx.frame_start && par_bad;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            len_q        <= LEN_W'(MIN_DATA_LEN);
            chk_q        <= 1'b0;
            mode_q       <= PAR_EVEN;
            acc          <= 1'b0;
            data_bits    <= '0;
            parity_done  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            parity_done <= 1'b0;
            if (start) begin
                len_q        <= len_clamped;
                chk_q        <= par_chk_en;
                mode_q       <= par_mode;
                cnt          <= '0;
                acc          <= 1'b0;
                data_bits    <= '0;
                parity_error <= 1'b0;
                state        <= ST_DATA;
            end else begin
                case (state)
                    ST_DATA: begin
                        if (rx.bit_valid) begin
                            data_bits[cnt[IDX_W-1:0]] <= rx.sampled_bit;
                            acc <= acc ^ rx.sampled_bit;
                            cnt <= cnt + LEN_W'(1);
                            if (last_bit) begin
                                state       <= chk_q ? ST_PARITY : ST_DONE;
                                parity_done <= !chk_q;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (rx.bit_valid) begin
                            parity_error <= par_bad;
                            parity_done  <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    parity_err_counter #(.CNT_W(CNT_W)) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (err_cnt_clr),
        .count (err_count)
    );
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = err_cnt_clr ^ err_inc;
    assign err_count         = '0;
`endif

endmodule
